// File: rtl/dpr_arbiter.sv
// Four-requester round-robin arbiter in front of a dual-port synchronous RAM.
// Each cycle, up to two eligible requesters are issued, one per RAM port.
// If the second pick would hit the same address as the first and either access
// is a write, the second pick is held back and retried in a later cycle.
// Read data returns two cycles after grant into a per-requester response slot.
module dpr_arbiter #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic [3:0]             req,
  input  logic [3:0]             req_we,
  input  logic [4*ADDR_SIZE-1:0] req_addr,
  input  logic [4*DATA_SIZE-1:0] req_wdata,
  output logic [3:0]             gnt,

  output logic [3:0]             rsp_valid,
  output logic [4*DATA_SIZE-1:0] rsp_data,

  output logic                   ram_en_a,
  output logic                   ram_we_a,
  output logic [ADDR_SIZE-1:0]   ram_addr_a,
  output logic [DATA_SIZE-1:0]   ram_din_a,
  input  logic [DATA_SIZE-1:0]   ram_dout_a,

  output logic                   ram_en_b,
  output logic                   ram_we_b,
  output logic [ADDR_SIZE-1:0]   ram_addr_b,
  output logic [DATA_SIZE-1:0]   ram_din_b,
  input  logic [DATA_SIZE-1:0]   ram_dout_b,

  output logic [7:0]             conflict_cnt
);

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CNT_W   = 8;

  // Per-requester views of the flattened request buses
  logic [ADDR_SIZE-1:0] addr_arr  [NUM_REQ];
  logic [DATA_SIZE-1:0] wdata_arr [NUM_REQ];

  // Response data slots, packed onto the flat output bus
  logic [DATA_SIZE-1:0] rsp_data_q [NUM_REQ];

  // Round-robin scan start
  logic [ID_W-1:0] rr_ptr;

  // Selection results for this cycle
  logic [3:0]      eligible_c;
  logic [ID_W-1:0] scan_idx_c;
  logic            sel_a_vld_c;
  logic [ID_W-1:0] sel_a_id_c;
  logic            sel_b_vld_c;
  logic [ID_W-1:0] sel_b_id_c;
  logic            conflict_c;
  logic            issue_b_c;
  logic [3:0]      gnt_nxt_c;

  // Read-tracking pipelines: stage 0 aligns with the grant cycle,
  // stage 1 with the cycle in which ram_dout is valid
  logic            rd0_vld_a;
  logic [ID_W-1:0] rd0_id_a;
  logic            rd1_vld_a;
  logic [ID_W-1:0] rd1_id_a;
  logic            rd0_vld_b;
  logic [ID_W-1:0] rd0_id_b;
  logic            rd1_vld_b;
  logic [ID_W-1:0] rd1_id_b;
  logic [3:0]      rsp_vld_nxt_c;

  // Unpack the request and response buses into per-requester slots
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign addr_arr[g]                            = req_addr[g*ADDR_SIZE +: ADDR_SIZE];
    assign wdata_arr[g]                           = req_wdata[g*DATA_SIZE +: DATA_SIZE];
    assign rsp_data[g*DATA_SIZE +: DATA_SIZE]     = rsp_data_q[g];
  end

  // A requester that was granted last cycle is masked for one cycle
  assign eligible_c = req & ~gnt;

  // Round-robin scan from rr_ptr: the first eligible hit goes to port A,
  // the second goes to port B
  always_comb begin
    sel_a_vld_c = 1'b0;
    sel_a_id_c  = '0;
    sel_b_vld_c = 1'b0;
    sel_b_id_c  = '0;
    scan_idx_c  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx_c = rr_ptr + ID_W'(k);
      if (eligible_c[scan_idx_c]) begin
        if (!sel_a_vld_c) begin
          sel_a_vld_c = 1'b1;
          sel_a_id_c  = scan_idx_c;
        end else if (!sel_b_vld_c) begin
          sel_b_vld_c = 1'b1;
          sel_b_id_c  = scan_idx_c;
        end
      end
    end
  end

  // Hold back port B on a same-address pair that includes a write
  always_comb begin
    conflict_c = 1'b0;
    if (sel_a_vld_c && sel_b_vld_c &&
        (addr_arr[sel_a_id_c] == addr_arr[sel_b_id_c]) &&
        (req_we[sel_a_id_c] || req_we[sel_b_id_c])) begin
      conflict_c = 1'b1;
    end
    issue_b_c = sel_b_vld_c && !conflict_c;
  end

  // Grant vector for the next cycle
  always_comb begin
    gnt_nxt_c = '0;
    if (sel_a_vld_c) begin
      gnt_nxt_c[sel_a_id_c] = 1'b1;
    end
    if (issue_b_c) begin
      gnt_nxt_c[sel_b_id_c] = 1'b1;
    end
  end

  // Grant register and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      gnt <= gnt_nxt_c;
      if (issue_b_c) begin
        rr_ptr <= sel_b_id_c + ID_W'(1);
      end else if (sel_a_vld_c) begin
        rr_ptr <= sel_a_id_c + ID_W'(1);
      end
    end
  end

  // RAM port A command; address and data hold when the port is idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_en_a   <= 1'b0;
      ram_we_a   <= 1'b0;
      ram_addr_a <= '0;
      ram_din_a  <= '0;
    end else begin
      ram_en_a <= sel_a_vld_c;
      ram_we_a <= sel_a_vld_c && req_we[sel_a_id_c];
      if (sel_a_vld_c) begin
        ram_addr_a <= addr_arr[sel_a_id_c];
        ram_din_a  <= wdata_arr[sel_a_id_c];
      end
    end
  end

  // RAM port B command; address and data hold when the port is idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_en_b   <= 1'b0;
      ram_we_b   <= 1'b0;
      ram_addr_b <= '0;
      ram_din_b  <= '0;
    end else begin
      ram_en_b <= issue_b_c;
      ram_we_b <= issue_b_c && req_we[sel_b_id_c];
      if (issue_b_c) begin
        ram_addr_b <= addr_arr[sel_b_id_c];
        ram_din_b  <= wdata_arr[sel_b_id_c];
      end
    end
  end

  // Saturating count of cycles with a withheld port-B grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (conflict_c && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  // In-flight read tracking for both ports
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd0_vld_a <= 1'b0;
      rd0_id_a  <= '0;
      rd1_vld_a <= 1'b0;
      rd1_id_a  <= '0;
      rd0_vld_b <= 1'b0;
      rd0_id_b  <= '0;
      rd1_vld_b <= 1'b0;
      rd1_id_b  <= '0;
    end else begin
      rd0_vld_a <= sel_a_vld_c && !req_we[sel_a_id_c];
      rd0_id_a  <= sel_a_id_c;
      rd1_vld_a <= rd0_vld_a;
      rd1_id_a  <= rd0_id_a;
      rd0_vld_b <= issue_b_c && !req_we[sel_b_id_c];
      rd0_id_b  <= sel_b_id_c;
      rd1_vld_b <= rd0_vld_b;
      rd1_id_b  <= rd0_id_b;
    end
  end

  // Response valid pulses for reads whose data is on ram_dout this cycle
  always_comb begin
    rsp_vld_nxt_c = '0;
    if (rd1_vld_a) begin
      rsp_vld_nxt_c[rd1_id_a] = 1'b1;
    end
    if (rd1_vld_b) begin
      rsp_vld_nxt_c[rd1_id_b] = 1'b1;
    end
  end

  // Capture read data into the owning requester's slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_data_q[i] <= '0;
      end
    end else begin
      rsp_valid <= rsp_vld_nxt_c;
      if (rd1_vld_a) begin
        rsp_data_q[rd1_id_a] <= ram_dout_a;
      end
      if (rd1_vld_b) begin
        rsp_data_q[rd1_id_b] <= ram_dout_b;
      end
    end
  end

endmodule

// File: tb/tb_dpr_arbiter.sv
// Directed bench for dpr_arbiter with a behavioural dual-port RAM.
module tb_dpr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        ram_en_a, ram_we_a, ram_en_b, ram_we_b;
  logic [7:0]  ram_addr_a, ram_din_a, ram_dout_a;
  logic [7:0]  ram_addr_b, ram_din_b, ram_dout_b;
  logic [7:0]  conflict_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [256];

  dpr_arbiter #(.ADDR_SIZE(8), .DATA_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_en_a(ram_en_a), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a),
    .ram_din_a(ram_din_a), .ram_dout_a(ram_dout_a),
    .ram_en_b(ram_en_b), .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b),
    .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous read-first dual-port RAM
  always @(posedge clk) begin
    if (ram_en_a) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
      ram_dout_a <= mem[ram_addr_a];
    end
    if (ram_en_b) begin
      if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
      ram_dout_b <= mem[ram_addr_b];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, sample just after the edge, and drop granted requests
  task automatic tick();
    @(posedge clk);
    #1;
    req = req & ~gnt;
  endtask

  task automatic set_req(input int i, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata);
    req_we[i]          = we;
    req_addr[i*8 +: 8] = addr;
    req_wdata[i*8 +: 8] = wdata;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;
    for (int i = 0; i < 4; i++) mem[8'h20 + i] = 8'hC0 + 8'(i);
    rst_n     = 1'b0;
    req       = 4'hF;
    req_we    = 4'h0;
    req_addr  = 32'h33221100;
    req_wdata = 32'h0;

    // Reset with all requests held
    @(posedge clk); @(posedge clk); #1;
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_en_a", 64'(ram_en_a), 64'h0);
    check("rst_en_b", 64'(ram_en_b), 64'h0);
    check("rst_cnt", 64'(conflict_cnt), 64'h0);
    rst_n = 1'b1;
    tick();
    check("rel_gnt", 64'(gnt), 64'h3);
    check("rel_en_a", 64'(ram_en_a), 64'h1);
    check("rel_addr_a", 64'(ram_addr_a), 64'h00);
    check("rel_addr_b", 64'(ram_addr_b), 64'h11);
    tick();
    check("rel_gnt2", 64'(gnt), 64'hC);
    tick(); tick(); tick();

    // Four distinct reads, two per cycle
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h20 + 8'(i), 8'h00);
    req = 4'hF;
    tick();
    check("rr4_gnt1", 64'(gnt), 64'h3);
    check("rr4_addr_b", 64'(ram_addr_b), 64'h21);
    tick();
    check("rr4_gnt2", 64'(gnt), 64'hC);
    tick();
    check("rr4_rv1", 64'(rsp_valid), 64'h3);
    check("rr4_d01", 64'(rsp_data[15:0]), 64'hC1C0);
    tick();
    check("rr4_rv2", 64'(rsp_valid), 64'hC);
    check("rr4_d23", 64'(rsp_data[31:16]), 64'hC3C2);
    check("rr4_ptr", 64'(dut.rr_ptr), 64'h0);
    tick();

    // Single read of preloaded 0x10
    set_req(0, 1'b0, 8'h10, 8'h00);
    req = 4'h1;
    tick();
    check("rd_gnt", 64'(gnt), 64'h1);
    check("rd_en_a", 64'(ram_en_a), 64'h1);
    check("rd_we_a", 64'(ram_we_a), 64'h0);
    check("rd_addr_a", 64'(ram_addr_a), 64'h10);
    check("rd_en_b", 64'(ram_en_b), 64'h0);
    tick();
    check("rd_rv_early", 64'(rsp_valid), 64'h0);
    tick();
    check("rd_rv", 64'(rsp_valid), 64'h1);
    check("rd_data0", 64'(rsp_data[7:0]), 64'h5A);
    tick();

    // Write/read conflict on 0x40 with rr_ptr = 1
    check("cf_ptr", 64'(dut.rr_ptr), 64'h1);
    set_req(1, 1'b1, 8'h40, 8'h22);
    set_req(2, 1'b0, 8'h40, 8'h00);
    req = 4'h6;
    tick();
    check("cf_gnt1", 64'(gnt), 64'h2);
    check("cf_cnt1", 64'(conflict_cnt), 64'h1);
    check("cf_we_a", 64'(ram_we_a), 64'h1);
    check("cf_din_a", 64'(ram_din_a), 64'h22);
    check("cf_en_b", 64'(ram_en_b), 64'h0);
    tick();
    check("cf_gnt2", 64'(gnt), 64'h4);
    check("cf_addr_a", 64'(ram_addr_a), 64'h40);
    tick();
    check("cf_rv_early", 64'(rsp_valid), 64'h0);
    tick();
    check("cf_rv", 64'(rsp_valid), 64'h4);
    check("cf_data2", 64'(rsp_data[23:16]), 64'h22);
    check("cf_data0_held", 64'(rsp_data[7:0]), 64'h5A);
    tick();

    // Requester 3 reads 0x40 alone, moving rr_ptr back to 0
    set_req(3, 1'b0, 8'h40, 8'h00);
    req = 4'h8;
    tick();
    check("r3_gnt", 64'(gnt), 64'h8);
    tick(); tick();
    check("r3_rv", 64'(rsp_valid), 64'h8);
    check("r3_data3", 64'(rsp_data[31:24]), 64'h22);
    tick();

    // Two writes to 0x07 serialize, requester 0 first
    set_req(0, 1'b1, 8'h07, 8'hAA);
    set_req(3, 1'b1, 8'h07, 8'hBB);
    req = 4'h9;
    tick();
    check("ww_gnt1", 64'(gnt), 64'h1);
    check("ww_din1", 64'(ram_din_a), 64'hAA);
    check("ww_cnt", 64'(conflict_cnt), 64'h2);
    tick();
    check("ww_gnt2", 64'(gnt), 64'h8);
    check("ww_din2", 64'(ram_din_a), 64'hBB);
    tick();
    check("ww_mem", 64'(mem[8'h07]), 64'hBB);
    check("ww_rv", 64'(rsp_valid), 64'h0);
    tick();

    // Simultaneous reads of the same address on both ports
    set_req(1, 1'b0, 8'h07, 8'h00);
    set_req(2, 1'b0, 8'h07, 8'h00);
    req = 4'h6;
    tick();
    check("rr_gnt", 64'(gnt), 64'h6);
    check("rr_addr_b", 64'(ram_addr_b), 64'h07);
    check("rr_cnt", 64'(conflict_cnt), 64'h2);
    tick(); tick();
    check("rr_rv", 64'(rsp_valid), 64'h6);
    check("rr_data12", 64'(rsp_data[23:8]), 64'hBBBB);
    tick();

    // Drive conflict_cnt into saturation
    set_req(0, 1'b1, 8'h50, 8'h01);
    set_req(1, 1'b0, 8'h50, 8'h00);
    for (int n = 0; n < 260; n++) begin
      req = 4'h3;
      tick(); tick(); tick();
    end
    check("sat_cnt", 64'(conflict_cnt), 64'hFF);

    // Reset in the cycle after a read grant
    set_req(0, 1'b0, 8'h10, 8'h00);
    req = 4'h1;
    tick();
    check("mr_gnt", 64'(gnt), 64'h1);
    rst_n = 1'b0;
    tick();
    check("mr_gnt0", 64'(gnt), 64'h0);
    check("mr_rv", 64'(rsp_valid), 64'h0);
    check("mr_data", 64'(rsp_data), 64'h0);
    check("mr_cmd_a", 64'({ram_en_a, ram_we_a, ram_addr_a, ram_din_a}), 64'h0);
    check("mr_cmd_b", 64'({ram_en_b, ram_we_b, ram_addr_b, ram_din_b}), 64'h0);
    check("mr_cnt", 64'(conflict_cnt), 64'h0);
    check("mr_ptr", 64'(dut.rr_ptr), 64'h0);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("mr_no_rsp", 64'(rsp_valid), 64'h0);
      check("mr_idle_gnt", 64'(gnt), 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dpr_arbiter.md
DPR_ARBITER -- requirements
Module: dpr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8: RAM address width.
REQ-002 SHALL have parameter DATA_SIZE, default 8: RAM data width.
REQ-003 SHALL have ports clk (in, 1) and rst_n (in, 1): single clock; reset is synchronous and active-low.
REQ-004 SHALL have port req (in, 4): per-requester access request, held high until gnt.
REQ-005 SHALL have port req_we (in, 4): per-requester write enable (1 = write, 0 = read).
REQ-006 SHALL have port req_addr (in, 4*ADDR_SIZE): requester i at bits [i*ADDR_SIZE +: ADDR_SIZE].
REQ-007 SHALL have port req_wdata (in, 4*DATA_SIZE): requester i at bits [i*DATA_SIZE +: DATA_SIZE].
REQ-008 SHALL have port gnt (out, 4): one-cycle pulse meaning the request is issued to RAM this cycle.
REQ-009 SHALL have ports rsp_valid (out, 4) and rsp_data (out, 4*DATA_SIZE): read-return pulse and read data per requester.
REQ-010 SHALL have outputs ram_en_a, ram_we_a (1 each), ram_addr_a (ADDR_SIZE) and ram_din_a (DATA_SIZE), plus input ram_dout_a (DATA_SIZE), forming the RAM port A connection; port B (ram_*_b) SHALL be identical.
REQ-011 SHALL drive ram_*, gnt, rsp_valid and rsp_data directly from flops.
REQ-012 SHALL have conflict_cnt (out, 8): saturating count of cycles in which a grant was withheld because of an address conflict.

Function
REQ-013 SHALL evaluate eligibility every cycle: eligible[i] = req[i] and not gnt[i].
REQ-014 SHALL scan eligible requesters round-robin, starting at rr_ptr (2 bits), wrapping from 3 to 0.
REQ-015 SHALL register the first eligible requester found as port A and the second as port B, asserting gnt for each in the same cycle as its ram_en.
REQ-016 SHALL withhold port B when both selected requesters have equal addresses and at least one of them is a write; in that case ram_en_b = 0, the second requester remains eligible and conflict_cnt increments (saturating at 0xFF).
REQ-017 SHALL leave a port's ram_en, ram_we and gnt bits at 0 when that port has no selected requester; its address and data SHALL hold their previous values.
REQ-018 SHALL update rr_ptr to (index of the last granted requester + 1) mod 4 after any grant, and SHALL leave rr_ptr unchanged when there is no grant.
REQ-019 SHALL have read latency as follows: for a read granted in cycle N, the RAM samples at the end of N, ram_dout is captured at the end of N+1, and rsp_valid[i] = 1 with rsp_data slot i updated in cycle N+2.
REQ-020 SHALL track an in-flight read per port with a 2-stage valid/ID pipeline, and SHALL sample ram_dout_x only when a read on that port is in flight.
REQ-021 SHALL produce no rsp_valid for writes; a write completes at the RAM edge ending its gnt cycle.
REQ-022 SHALL support simultaneous reads on both ports (including the same address), and both rsp_valid bits SHALL then pulse in the same cycle.
REQ-023 SHALL hold each rsp_data slot until that slot's next read return.
REQ-024 SHALL NOT have any requester granted in two consecutive cycles for one held request; requesters are required to drop or change req after gnt.

Reset
REQ-025 SHALL, on rst_n = 0 at a clk edge, clear gnt, rsp_valid, rsp_data, ram_en_a/b, ram_we_a/b, ram_addr_a/b, ram_din_a/b, rr_ptr, conflict_cnt and both read pipelines to 0.
REQ-026 SHALL cancel in-flight reads on reset mid-operation, with no rsp_valid after rst_n returns high.

Verification
REQ-027 SHALL be tested so that: rst_n = 0 for 2 cycles with req = 4'hF -> gnt = 0, ram_en_a/b = 0, conflict_cnt = 0; the first grant after release goes to requester 0 on port A.
REQ-028 SHALL be tested so that: RAM[0x10] = 0x5A and requester 0 reads 0x10 -> gnt = 0001 with ram_en_a = 1, ram_we_a = 0, ram_addr_a = 0x10 in the same cycle, and rsp_valid[0] = 1 with rsp_data slot 0 = 0x5A two cycles later.
REQ-029 SHALL be tested so that: all 4 requesters read distinct addresses, each holding req until gnt -> gnt = 0011, then gnt = 1100, and rr_ptr = 0 afterwards.
REQ-030 SHALL be tested so that: with rr_ptr = 1, requester 1 writes 0x22 to 0x40 while requester 2 reads 0x40 -> gnt = 0010 and conflict_cnt = 1, next cycle gnt = 0100, and rsp_data slot 2 = 0x22.
REQ-031 SHALL be tested so that: requesters 0 and 3 both write address 0x07 (0xAA, 0xBB) -> the writes are serialized with requester 0 first, and RAM[0x07] = 0xBB at the end.
REQ-032 SHALL be tested so that: rst_n = 0 in the cycle after a read gnt -> no rsp_valid and all outputs 0.
